// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller.
// Holds the FSM state enum, channel count, select width and a small
// helper used to assemble the captured word.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Returns word with bit idx replaced by val.
  function automatic logic [NUM_CH-1:0] with_bit(
    input logic [NUM_CH-1:0] word,
    input logic [SEL_W-1:0]  idx,
    input logic              val
  );
    logic [NUM_CH-1:0] res;
    res      = word;
    res[idx] = val;
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Settle timer for the mux scan controller.
// Counts cycles while enabled and flags the last settle cycle, so that the
// enclosing FSM stays in SETTLE for exactly SETTLE_CYC cycles.
module settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Cycle counter: cleared outside SETTLE, advanced once per SETTLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = en && (cnt == CNT_W'(SETTLE_CYC - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequential scan controller for the 4-to-1 mux stage.
// Steps se1 through channels 0..3, waits SETTLE_CYC cycles per channel,
// captures mux_out into a shadow register and publishes the whole word
// atomically on sample together with a one-cycle done pulse.
// Optional macro MUX_SCAN_CONT_EN: when defined, a scan restarts straight
// from DONE while start is held high (continuous scanning).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  se1,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] sample
);

  state_t            state;
  logic [NUM_CH-1:0] shadow;
  logic              tmr_clr;
  logic              tmr_en;
  logic              expired;

  assign tmr_en  = (state == SETTLE);
  assign tmr_clr = (state != SETTLE);

  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  // Scan FSM with registered outputs; done and sample are loaded on the
  // edge entering DONE so both are visible for the whole DONE cycle,
  // including the bit captured from the last channel on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      se1    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sample <= '0;
      shadow <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SETTLE;
            se1   <= '0;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (expired) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          shadow <= with_bit(shadow, se1, mux_out);
          if (se1 == SEL_W'(NUM_CH - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            sample <= with_bit(shadow, se1, mux_out);
          end else begin
            state <= SETTLE;
            se1   <= se1 + SEL_W'(1);
          end
        end
        DONE: begin
          done <= 1'b0;
`ifdef MUX_SCAN_CONT_EN
          if (start) begin
            state <= SETTLE;
            se1   <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed testbench for mux_scan_ctrl with SETTLE_CYC = 2.
// A behavioural 4-to-1 mux feeds mux_out from mux_in[se1].
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mux_out;
  logic [1:0] se1;
  logic       busy;
  logic       done;
  logic [3:0] sample;
  logic [3:0] mux_in;

  int checks = 0;
  int errors = 0;

`ifdef MUX_SCAN_CONT_EN
  localparam int PERIOD = 13;
`else
  localparam int PERIOD = 14;
`endif

  always #5 clk = ~clk;

  assign mux_out = mux_in[se1];

  mux_scan_ctrl #(
    .SETTLE_CYC (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mux_out (mux_out),
    .se1     (se1),
    .busy    (busy),
    .done    (done),
    .sample  (sample)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] ins);
    start  = st;
    mux_in = ins;
    @(posedge clk);
    #1;
  endtask

  // Starts a scan from IDLE and checks every cycle up to busy dropping.
  task automatic scanAndCheck(input logic [3:0] ins, input logic [3:0] prev,
                              input logic [3:0] exp);
    applyStimulus(1'b1, ins);
    checkOutput("start_busy", 8'(busy), 8'd1);
    checkOutput("start_se1", 8'(se1), 8'd0);
    for (int k = 2; k <= 13; k++) begin
      applyStimulus(1'b0, ins);
      if (k <= 12) begin
        checkOutput($sformatf("se1_e%0d", k), 8'(se1), 8'((k - 1) / 3));
        checkOutput($sformatf("hold_e%0d", k), 8'(sample), 8'(prev));
        checkOutput($sformatf("nodone_e%0d", k), 8'(done), 8'd0);
      end else begin
        checkOutput("done_pulse", 8'(done), 8'd1);
        checkOutput("sample_word", 8'(sample), 8'(exp));
        checkOutput("done_busy", 8'(busy), 8'd1);
      end
    end
    applyStimulus(1'b0, ins);
    checkOutput("after_done", 8'(done), 8'd0);
    checkOutput("after_busy", 8'(busy), 8'd0);
    checkOutput("after_sample", 8'(sample), 8'(exp));
  endtask

  initial begin
    int ndone;
    int first_edge;
    int edges[$];

    // Reset state
    rst_n  = 1'b0;
    start  = 1'b0;
    mux_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_se1", 8'(se1), 8'd0);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    checkOutput("rst_done", 8'(done), 8'd0);
    checkOutput("rst_sample", 8'(sample), 8'd0);
    rst_n = 1'b1;
    repeat (5) applyStimulus(1'b0, 4'b1111);
    checkOutput("idle_busy", 8'(busy), 8'd0);
    checkOutput("idle_se1", 8'(se1), 8'd0);
    checkOutput("idle_done", 8'(done), 8'd0);

    // Single scan: in0..in3 = 1,0,1,1
    scanAndCheck(4'b1101, 4'b0000, 4'b1101);
    checkOutput("idle_se1_hold", 8'(se1), 8'd3);

    // Atomicity: in0..in3 = 0,1,0,0
    scanAndCheck(4'b0010, 4'b1101, 4'b0010);

    // Start pulses while busy are ignored
    ndone = 0;
    first_edge = 0;
    applyStimulus(1'b1, 4'b1001);
    for (int k = 2; k <= 22; k++) begin
      applyStimulus((k == 5 || k == 9 || k == 13), 4'b1001);
      if (done === 1'b1) begin
        ndone++;
        if (first_edge == 0) first_edge = k;
      end
    end
    checkOutput("ign_done_count", 8'(ndone), 8'd1);
    checkOutput("ign_done_edge", 8'(first_edge), 8'd13);
    checkOutput("ign_sample", 8'(sample), 8'b1001);

    // Reset mid-scan while se1 = 2
    applyStimulus(1'b1, 4'b0110);
    for (int k = 2; k <= 7; k++) applyStimulus(1'b0, 4'b0110);
    checkOutput("mid_se1", 8'(se1), 8'd2);
    rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_se1", 8'(se1), 8'd0);
    checkOutput("mid_rst_busy", 8'(busy), 8'd0);
    checkOutput("mid_rst_done", 8'(done), 8'd0);
    checkOutput("mid_rst_sample", 8'(sample), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) applyStimulus(1'b0, 4'b0110);
    scanAndCheck(4'b0110, 4'b0000, 4'b0110);

    // Start held high: back-to-back scans
    for (int k = 1; k <= 45; k++) begin
      applyStimulus(1'b1, 4'b1010);
      if (done === 1'b1) edges.push_back(k);
    end
    checkOutput("cont_ndone_ge3", 8'(edges.size() >= 3), 8'd1);
    if (edges.size() >= 3) begin
      checkOutput("cont_first", 8'(edges[0]), 8'd13);
      checkOutput("cont_gap1", 8'(edges[1] - edges[0]), 8'(PERIOD));
      checkOutput("cont_gap2", 8'(edges[2] - edges[1]), 8'(PERIOD));
    end
    repeat (20) applyStimulus(1'b0, 4'b1010);
    checkOutput("cont_end_busy", 8'(busy), 8'd0);
    checkOutput("cont_sample", 8'(sample), 8'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential scan controller that sits on both sides of the 4-to-1 mux stage. It drives the mux select `se1` through channels 0..3, waits a programmable settle time on each channel, and captures the mux `out` bit. On completion it presents all four captured bits as one atomically updated 4-bit word with a one-cycle `done` pulse. It is the block that turns the combinational mux into a usable polled input port.

## Interface
- `SETTLE_CYC`, default 2: number of settle cycles per channel after `se1` changes and before sampling; legal range 1..15; 0 is illegal.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: scan request, sampled only in IDLE.
- `mux_out` input 1: the mux `out` bit, driven by the mux stage.
- `se1` output 2: mux select, registered.
- `busy` output 1: high while a scan is in progress.
- `done` output 1: one-cycle pulse when `sample` is updated.
- `sample` output 4: last completed scan; bit i holds the value captured from channel i.

## Operation
- Reset values:
  - `se1` = 0, `busy` = 0, `done` = 0, `sample` = 4'b0000.
  - Internal shadow register = 0; state = IDLE; settle counter = 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `start` = 1: go to SETTLE with `se1` = 0 and counter = 0.
  - Otherwise: hold.
- SETTLE:
  - Counter increments each cycle.
  - Leave for SAMPLE when counter = SETTLE_CYC-1, so SETTLE lasts exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle):
  - Write `shadow[se1]` <= `mux_out`.
  - If `se1` = 3: go to DONE.
  - Otherwise: `se1` <= `se1`+1, counter <= 0, go to SETTLE.
- DONE (1 cycle):
  - `sample` <= shadow; `done` = 1.
  - Next state is IDLE (see Configuration).
- `se1` wraps 3→0 only at the next scan start; it never increments past 3.
- `busy` = 1 in SETTLE, SAMPLE and DONE; `busy` = 0 in IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- `sample` never shows a partial scan. Between DONE pulses it holds its previous value.
- Reset asserted mid-scan aborts immediately: all outputs return to reset values and the shadow contents are discarded.
- Counter width is $clog2(SETTLE_CYC+1). Arithmetic is unsigned and never overflows in the legal range.

## Timing
- `start` high at edge 0 (in IDLE): `busy` and `se1` = 0 are visible after edge 1.
- Each channel takes SETTLE_CYC+1 cycles.
- `done` is high in the cycle after edge 1+4·(SETTLE_CYC+1). With the default SETTLE_CYC = 2, that is after edge 13.
- `sample` is valid in the same cycle `done` is high.
- `mux_out` is captured at the end of the SAMPLE cycle, so the mux has SETTLE_CYC+1 cycles to settle after each select change.
- One-shot period with `start` held high: 4·(SETTLE_CYC+1)+2 cycles, because DONE and IDLE each take one cycle.

## Configuration
- `MUX_SCAN_CONT_EN` defined: DONE goes directly to SETTLE with `se1` = 0 when `start` is high, giving continuous scanning with period 4·(SETTLE_CYC+1)+1. When `start` is low, DONE goes to IDLE.
- Not defined: DONE always goes to IDLE, and every scan needs `start` sampled in IDLE.

## Structure
- Package `mux_scan_pkg` holds:
  - The state enum (IDLE, SETTLE, SAMPLE, DONE).
  - `NUM_CH` = 4.
  - `SEL_W` = 2.
- One sub-module, `settle_timer`:
  - Parameterised by SETTLE_CYC.
  - Inputs: `clr` and `en`.
  - Output: `expired`.
  - Instantiated once.
- The FSM, `se1` register, shadow register and output register live in `mux_scan_ctrl`.

## Test plan
- Reset check: hold `rst_n` = 0, then release → `se1` = 0, `busy` = 0, `done` = 0, `sample` = 0000; no activity without `start`.
- Single scan: mux stage with in0..in3 = 1,0,1,1 and SETTLE_CYC = 2, pulse `start` one cycle → `se1` steps 0,1,2,3, each held 3 cycles; `done` pulses once in cycle 13 with `sample` = 4'b1101; `busy` drops the next cycle.
- Atomicity: after a scan with result 1101, set in0..in3 = 0,1,0,0 and start again → `sample` stays 1101 until the new `done`, then becomes 0010.
- Ignored start: pulse `start` while `busy` = 1 → exactly one `done` is produced and the timing is unchanged.
- Reset mid-scan: assert `rst_n` = 0 while `se1` = 2 → outputs return to reset values immediately; a later `start` gives a full, correct scan.
- Continuous mode (`MUX_SCAN_CONT_EN` defined): hold `start` high for 3 scans → `done` pulses are 13 cycles apart. Without the macro: pulses are 14 cycles apart.
